// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared encodings for the multi-cycle ALU sequencer
package alu_seq_pkg;

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROR = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;

  localparam int SHIFT_CLAMP = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/alu_seq_step.sv
// rtl/alu_seq_step.sv - one bit-step of shift/rotate/multiply on the working registers
module alu_seq_step
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] w,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] mc,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] w_next,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] mc_next,
  output logic [WIDTH-1:0] m_next
);

  always_comb begin
    w_next   = w;
    acc_next = acc;
    mc_next  = mc;
    m_next   = m;
    case (op)
      OP_SLL: w_next = {w[WIDTH-2:0], 1'b0};
      OP_SRL: w_next = {1'b0, w[WIDTH-1:1]};
      OP_SRA: w_next = {w[WIDTH-1], w[WIDTH-1:1]};
      OP_ROR: w_next = {w[0], w[WIDTH-1:1]};
      OP_MUL: begin
        // shift-and-add; the carry out of acc is dropped so only the low WIDTH bits survive
        if (m[0]) acc_next = acc + mc;
        mc_next = {mc[WIDTH-2:0], 1'b0};
        m_next  = {1'b0, m[WIDTH-1:1]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_seq_controller.sv
// rtl/alu_seq_controller.sv - FSM, step counter and result registers for multi-cycle ALU ops
module alu_seq_controller
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [2:0]       OP,
  input  logic [WIDTH-1:0] OPERAND_A,
  input  logic [WIDTH-1:0] OPERAND_B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT,
  output logic             ZERO
);

  state_t           state;
  logic [2:0]       op_q;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] w, acc, mc, m;
  logic [WIDTH-1:0] w_next, acc_next, mc_next, m_next;
  logic [WIDTH-1:0] step_result;
  logic [CNT_W-1:0] n_start;

  function automatic logic [CNT_W-1:0] step_count(input logic [2:0] op, input logic [WIDTH-1:0] b);
    case (op)
      OP_SLL, OP_SRL, OP_SRA:
        step_count = (b >= WIDTH'(SHIFT_CLAMP)) ? CNT_W'(SHIFT_CLAMP) : CNT_W'(b);
      OP_ROR:  step_count = CNT_W'(b[2:0]);
      OP_MUL:  step_count = CNT_W'(WIDTH);
      default: step_count = '0;
    endcase
  endfunction

  alu_seq_step #(.WIDTH(WIDTH)) u_step (
    .op       (op_q),
    .w        (w),
    .acc      (acc),
    .mc       (mc),
    .m        (m),
    .w_next   (w_next),
    .acc_next (acc_next),
    .mc_next  (mc_next),
    .m_next   (m_next)
  );

  assign n_start     = step_count(OP, OPERAND_B);
  assign step_result = (op_q == OP_MUL) ? acc_next : w_next;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= S_IDLE;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      RESULT <= '0;
      ZERO   <= 1'b0;
      op_q   <= '0;
      cnt    <= '0;
      w      <= '0;
      acc    <= '0;
      mc     <= '0;
      m      <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          DONE <= 1'b0;
          if (START) begin
            op_q <= OP;
            cnt  <= n_start;
            w    <= OPERAND_A;
            acc  <= '0;
            mc   <= OPERAND_A;
            m    <= OPERAND_B;
            if (n_start != '0) begin
              state <= S_RUN;
              BUSY  <= 1'b1;
            end else begin
              // zero-step ops (including reserved codes) pass A straight through
              state  <= S_DONE;
              DONE   <= 1'b1;
              RESULT <= OPERAND_A;
              ZERO   <= (OPERAND_A == '0);
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          w   <= w_next;
          acc <= acc_next;
          mc  <= mc_next;
          m   <= m_next;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state  <= S_DONE;
            BUSY   <= 1'b0;
            DONE   <= 1'b1;
            RESULT <= step_result;
            ZERO   <= (step_result == '0);
          end
        end
        default: begin
          state <= S_IDLE;
          BUSY  <= 1'b0;
          DONE  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_controller.sv
// tb/tb_alu_seq_controller.sv - self-checking bench for alu_seq_controller
module tb_alu_seq_controller;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       START = 1'b0;
  logic [2:0] OP = 3'd0;
  logic [7:0] OPERAND_A = 8'd0;
  logic [7:0] OPERAND_B = 8'd0;
  logic       BUSY, DONE, ZERO;
  logic [7:0] RESULT;

  int n_cmp = 0;
  int n_bad = 0;

  alu_seq_controller #(.WIDTH(8), .CNT_W(4)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .START     (START),
    .OP        (OP),
    .OPERAND_A (OPERAND_A),
    .OPERAND_B (OPERAND_B),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .RESULT    (RESULT),
    .ZERO      (ZERO)
  );

  always #5 CLK = ~CLK;

  logic [2:0] d_op  [10] = '{3'd0, 3'd0, 3'd2, 3'd2, 3'd1, 3'd3, 3'd3, 3'd4, 3'd4, 3'd6};
  logic [7:0] d_a   [10] = '{8'h81, 8'h81, 8'h90, 8'h90, 8'h90, 8'h81, 8'h5A, 8'h0D, 8'h10, 8'h3C};
  logic [7:0] d_b   [10] = '{8'd3, 8'd0, 8'd2, 8'd10, 8'd200, 8'd9, 8'd8, 8'd11, 8'h10, 8'h77};
  logic [7:0] d_res [10] = '{8'h08, 8'h81, 8'hE4, 8'hFF, 8'h00, 8'hC0, 8'h5A, 8'h8F, 8'h00, 8'h3C};
  int         d_n   [10] = '{3, 0, 2, 8, 8, 1, 0, 8, 8, 0};

  function automatic int ref_steps(input logic [2:0] op, input logic [7:0] b);
    int bi = int'(b);
    if (op <= 3'd2) return (bi > 8) ? 8 : bi;
    if (op == 3'd3) return bi % 8;
    if (op == 3'd4) return 8;
    return 0;
  endfunction

  function automatic logic [7:0] ref_result(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int n  = ref_steps(op, b);
    int ai = int'(a);
    int sa = (ai >= 128) ? ai - 256 : ai;
    case (op)
      3'd0:    return 8'((ai << n) & 255);
      3'd1:    return 8'(ai >> n);
      3'd2:    return 8'((sa >>> n) & 255);
      3'd3:    return 8'(((ai >> n) | (ai << (8 - n))) & 255);
      3'd4:    return 8'((ai * int'(b)) & 255);
      default: return a;
    endcase
  endfunction

  task automatic do_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       output int busy_n, output int done_at, output logic [7:0] res,
                       output logic z, output logic ok);
    @(negedge CLK);
    START = 1'b1; OP = op; OPERAND_A = a; OPERAND_B = b;
    @(negedge CLK);
    START = 1'b0; OP = 3'($urandom); OPERAND_A = 8'($urandom); OPERAND_B = 8'($urandom);
    busy_n = 0; done_at = -1; ok = 1'b0; res = 8'h00; z = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (DONE) begin
        ok = 1'b1; done_at = i; res = RESULT; z = ZERO;
        break;
      end
      if (BUSY) busy_n++;
      @(negedge CLK);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1; START = 1'b1; OP = 3'd4; OPERAND_A = 8'hFF; OPERAND_B = 8'hFF;
    repeat (3) @(negedge CLK);
    n_cmp++; if ({BUSY, DONE, ZERO} !== 3'b000) begin n_bad++; $display("FAIL reset_flags got=%b exp=000", {BUSY, DONE, ZERO}); end
    n_cmp++; if (RESULT !== 8'h00) begin n_bad++; $display("FAIL reset_result got=%h exp=00", RESULT); end
    START = 1'b0; RESET = 1'b0;
    @(negedge CLK);
    n_cmp++; if ({BUSY, DONE} !== 2'b00) begin n_bad++; $display("FAIL reset_idle got=%b exp=00", {BUSY, DONE}); end
  endtask

  task automatic test_directed();
    int bn, da; logic [7:0] r; logic z, ok;
    for (int k = 0; k < 10; k++) begin
      do_op(d_op[k], d_a[k], d_b[k], bn, da, r, z, ok);
      n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL dir%0d_timeout got=no_done exp=done", k); end
      n_cmp++; if (r !== d_res[k]) begin n_bad++; $display("FAIL dir%0d_result got=%h exp=%h", k, r, d_res[k]); end
      n_cmp++; if (z !== (d_res[k] == 8'h00)) begin n_bad++; $display("FAIL dir%0d_zero got=%b exp=%b", k, z, d_res[k] == 8'h00); end
      n_cmp++; if (bn != d_n[k] || da != d_n[k]) begin n_bad++; $display("FAIL dir%0d_timing busy=%0d done_at=%0d exp=%0d", k, bn, da, d_n[k]); end
    end
  endtask

  task automatic test_random();
    int bn, da, n; logic [7:0] r, a, b, e; logic [2:0] op; logic z, ok;
    for (int k = 0; k < 40; k++) begin
      op = 3'($urandom_range(0, 7));
      a  = 8'($urandom);
      b  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 10)) : 8'($urandom);
      if (k % 8 == 0) a = 8'h00;
      e = ref_result(op, a, b);
      n = ref_steps(op, b);
      do_op(op, a, b, bn, da, r, z, ok);
      n_cmp++; if (!ok || r !== e || z !== (e == 8'h00)) begin n_bad++; $display("FAIL rnd%0d op=%0d a=%h b=%h got=%h/%b exp=%h", k, op, a, b, r, z, e); end
      n_cmp++; if (bn != n || da != n) begin n_bad++; $display("FAIL rnd%0d_timing busy=%0d done_at=%0d exp=%0d", k, bn, da, n); end
    end
  endtask

  task automatic test_start_mid_run();
    int da = -1;
    @(negedge CLK); START = 1'b1; OP = 3'd4; OPERAND_A = 8'd13; OPERAND_B = 8'd11;
    @(negedge CLK); START = 1'b0;
    @(negedge CLK);
    @(negedge CLK); START = 1'b1; OP = 3'd0; OPERAND_A = 8'hFF; OPERAND_B = 8'd1;
    @(negedge CLK); START = 1'b0;
    for (int i = 3; i < 20; i++) begin
      if (DONE) begin da = i; break; end
      @(negedge CLK);
    end
    n_cmp++; if (da != 8) begin n_bad++; $display("FAIL midrun_done_at got=%0d exp=8", da); end
    n_cmp++; if (RESULT !== 8'h8F) begin n_bad++; $display("FAIL midrun_result got=%h exp=8f", RESULT); end
    @(negedge CLK);
    n_cmp++; if ({BUSY, DONE} !== 2'b00) begin n_bad++; $display("FAIL midrun_not_queued got=%b exp=00", {BUSY, DONE}); end
  endtask

  task automatic test_back_to_back();
    logic seen = 1'b0;
    @(negedge CLK); START = 1'b1; OP = 3'd0; OPERAND_A = 8'h81; OPERAND_B = 8'd3;
    @(negedge CLK); START = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (DONE) begin seen = 1'b1; break; end
      @(negedge CLK);
    end
    n_cmp++; if (!seen || RESULT !== 8'h08) begin n_bad++; $display("FAIL b2b_first got=%h done=%b exp=08", RESULT, seen); end
    START = 1'b1; OP = 3'd6; OPERAND_A = 8'h3C; OPERAND_B = 8'h55;
    @(negedge CLK);
    n_cmp++; if ({BUSY, DONE} !== 2'b01 || RESULT !== 8'h3C) begin n_bad++; $display("FAIL b2b_reserved got=%b/%h exp=01/3c", {BUSY, DONE}, RESULT); end
    OP = 3'd1; OPERAND_A = 8'h90; OPERAND_B = 8'd2;
    @(negedge CLK); START = 1'b0;
    n_cmp++; if ({BUSY, DONE} !== 2'b10) begin n_bad++; $display("FAIL b2b_no_bubble got=%b exp=10", {BUSY, DONE}); end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (DONE) begin seen = 1'b1; break; end
      @(negedge CLK);
    end
    n_cmp++; if (!seen || RESULT !== 8'h24) begin n_bad++; $display("FAIL b2b_third got=%h done=%b exp=24", RESULT, seen); end
  endtask

  task automatic test_reset_abort();
    int bn, da; logic [7:0] r; logic z, ok;
    logic seen = 1'b0;
    @(negedge CLK); START = 1'b1; OP = 3'd4; OPERAND_A = 8'd13; OPERAND_B = 8'd11;
    @(negedge CLK); START = 1'b0;
    repeat (4) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    n_cmp++; if ({BUSY, DONE, ZERO} !== 3'b000 || RESULT !== 8'h00) begin n_bad++; $display("FAIL abort_state got=%b/%h exp=000/00", {BUSY, DONE, ZERO}, RESULT); end
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (DONE) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL abort_no_done got=%b exp=0", seen); end
    do_op(3'd0, 8'h01, 8'd7, bn, da, r, z, ok);
    n_cmp++; if (!ok || r !== 8'h80 || bn != 7) begin n_bad++; $display("FAIL abort_followup got=%h busy=%0d exp=80/7", r, bn); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_mid_run();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_seq_controller.md
Name: alu_seq_controller

Overview:
Multi-cycle sequencer for the ALU operations that cannot complete in one combinational pass: logical shifts, arithmetic shift right, rotate right and 8-bit multiply.
- Accepts one operation per start pulse and iterates one bit-step per clock.
- Presents a registered result with a done pulse.
- Stalls the CPU via BUSY while iterating.
- Sits beside the combinational alu; the CPU control unit selects this block's RESULT for ALUOP codes 100–111.

Parameters:
WIDTH, 8, datapath width for operands and result.
CNT_W, 4, step-counter width; must hold WIDTH.

Ports:
CLK  input  1  system clock; all state changes on rising edge.
RESET  input  1  synchronous, active-high reset.
START  input  1  request; sampled only in IDLE or DONE state.
OP  input  3  operation code, captured with START.
OPERAND_A  input  WIDTH  data operand (multiplicand for MUL), captured with START.
OPERAND_B  input  WIDTH  shift/rotate amount or multiplier, captured with START.
BUSY  output  1  high while iterating (RUN state).
DONE  output  1  one-cycle pulse; RESULT/ZERO valid from this cycle.
RESULT  output  WIDTH  registered result, held until the next completion.
ZERO  output  1  registered, equals (RESULT == 0).

Behaviour:
- Clock and reset: one clock, CLK. RESET is synchronous, active-high.
- Reset values: state=IDLE; BUSY=0; DONE=0; RESULT=0; ZERO=0; working registers=0.
- Opcodes:
  - 000 SLL
  - 001 SRL
  - 010 SRA
  - 011 ROR
  - 100 MUL (unsigned, low WIDTH bits of product)
  - 101–111 reserved
- Step count N, fixed at capture:
  - SLL/SRL/SRA: N = min(OPERAND_B, 8), so OPERAND_B ≥ 8 clamps to 8.
  - ROR: N = OPERAND_B[2:0], i.e. amount mod 8.
  - MUL: N = 8 always; no early termination.
  - Reserved: N = 0, result = OPERAND_A.
- Per-step operation on working register W (loaded with OPERAND_A):
  - SLL: W = {W[6:0], 0}
  - SRL: W = {0, W[7:1]}
  - SRA: W = {W[7], W[7:1]}
  - ROR: W = {W[0], W[7:1]}
  - MUL: if M[0], ACC = ACC + MC (mod 2^8, carry discarded); then MC <<= 1, M >>= 1. ACC starts at 0, MC = OPERAND_A, M = OPERAND_B.
- FSM states: IDLE, RUN, DONE.
  - IDLE/DONE with START=1 at edge E0: capture OP and operands, load the counter with N.
    - If N > 0: go to RUN.
    - If N = 0: go to DONE; RESULT = OPERAND_A.
  - IDLE/DONE with START=0: DONE goes to IDLE; IDLE stays in IDLE.
  - RUN: one step per edge, counter decrements. On the edge that performs the Nth step, go to DONE and load RESULT/ZERO from the post-step value.
- Timing: DONE is high for exactly the cycle after edge E_N (E_0 when N=0). BUSY is high for the cycles after E0 through E_(N-1), i.e. N cycles.
- Handshake and boundary cases:
  - START while in RUN is ignored and not queued.
  - START during the DONE cycle is accepted; this gives back-to-back operation with no bubble.
  - Operand or OP changes after E0 have no effect.
  - RESULT and ZERO change only on entry to DONE and on RESET.
  - RESET during RUN aborts: next cycle state=IDLE and all outputs at reset values; no DONE pulse for the aborted op.
  - RESET and START in the same cycle: RESET wins.

Decomposition:
- Shared package alu_seq_pkg holds:
  - OP encodings (OP_SLL, OP_SRL, OP_SRA, OP_ROR, OP_MUL)
  - FSM state encoding (S_IDLE, S_RUN, S_DONE)
  - the SHIFT_CLAMP=8 constant
- One combinational sub-module, alu_seq_step, computes the next {W, ACC, MC, M} from the current values and OP. The controller holds the FSM, counter and registers.

Test Plan:
1. SLL, A=0x81, B=3 → BUSY for 3 cycles; DONE in the cycle after E3; RESULT=0x08, ZERO=0. SLL with B=0 → DONE in the cycle after E0, RESULT=0x81.
2. SRA, A=0x90, B=2 → RESULT=0xE4. SRA, A=0x90, B=10 → clamped to 8 steps, RESULT=0xFF. SRL, A=0x90, B=200 → RESULT=0x00, ZERO=1.
3. ROR, A=0x81, B=9 → 1 step, RESULT=0xC0. ROR, A=0x5A, B=8 → N=0, RESULT=0x5A, no BUSY.
4. MUL, A=13, B=11 → 8 BUSY cycles, RESULT=0x8F. MUL, A=0x10, B=0x10 → RESULT=0x00, ZERO=1 (overflow truncated).
5. START pulse mid-RUN with different operands → ignored, original result delivered. START held during the DONE cycle → second op begins with no idle cycle; reserved OP=110, A=0x3C → RESULT=0x3C with N=0.
6. RESET asserted after the 4th MUL step → next cycle BUSY=0, DONE=0, RESULT=0, no DONE pulse. A subsequent SLL, A=0x01, B=7 → RESULT=0x80.
